sd_mirror_rrmux: RTL and testbench
==================================

SD_MIRROR_RRMUX -- requirements
Module: sd_mirror_rrmux

Interface
REQ-001 Parameter W, default 8: data width of both paths.
REQ-002 Parameter M, default 4: number of mirror (dispatch) destinations.
REQ-003 Parameter N, default 4: number of round-robin mux inputs.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 m_c_srdy  input  1  dispatch item valid.
REQ-007 m_c_drdy  output  1  dispatch path can accept an item.
REQ-008 m_c_data  input  W  dispatch item.
REQ-009 m_c_dst_vld  input  M  destination mask, bit i = destination i.
REQ-010 m_p_srdy  output  M  per-destination item valid.
REQ-011 m_p_drdy  input  M  per-destination ready.
REQ-012 m_p_data  output  W  held item, common to all destinations.
REQ-013 r_c_srdy  input  N  per-input valid.
REQ-014 r_c_drdy  output  N  per-input ready.
REQ-015 r_c_data  input  N*W  input i data in bits i*W+W-1 : i*W.
REQ-016 r_p_srdy  output  1  mux output valid.
REQ-017 r_p_drdy  input  1  mux output ready.
REQ-018 r_p_data  output  W  data of granted input.
REQ-019 r_p_grant  output  N  one-hot current grant, 0 when no request.

Function
REQ-020 Transfer on any srdy/drdy pair SHALL occur when both are 1 at a rising clk edge.
REQ-021 Mirror SHALL hold a registered pending mask P (M bits) and data register D (W bits); m_p_srdy = P, m_p_data = D.
REQ-022 m_c_drdy SHALL be combinational: 1 iff P == 0.
REQ-023 On accept (m_c_srdy & m_c_drdy): D <= m_c_data; P <= m_c_dst_vld, or all ones if m_c_dst_vld == 0.
REQ-024 Each cycle with P != 0, P[i] SHALL clear when m_p_drdy[i] = 1; uncleared bits and D hold.
REQ-025 Mirror SHALL accept no new item in the cycle its last bit clears; minimum spacing between accepts is 2 cycles.
REQ-026 m_p_data SHALL remain stable while P != 0.
REQ-027 Mux SHALL be combinational-arbitrated (fast arbitration): r_p_srdy = OR of r_c_srdy, same cycle.
REQ-028 Grant SHALL be the first requesting input at an index strictly above the last-served index L, wrapping modulo N; grant[L] wins only if L is the sole requester.
REQ-029 r_p_data SHALL be the data slice of the granted input; all zeros when no grant.
REQ-030 r_c_drdy[i] SHALL equal grant[i] & r_p_drdy; at most one bit set.
REQ-031 L SHALL update to the granted index only on an output transfer (r_p_srdy & r_p_drdy); every transfer re-arbitrates (one item per grant).
REQ-032 With r_p_drdy = 0, grant SHALL stay on the same input while requests are unchanged; no starvation: each persistently requesting input is served within N transfers.
REQ-033 Mirror and mux SHALL operate independently and concurrently.

Reset
REQ-034 While reset = 0, asynchronously: P = 0, D = 0, L = N-1 (input 0 highest priority next), hence m_p_srdy = 0, m_c_drdy = 1.
REQ-035 Reset asserted mid-operation SHALL discard pending mirror deliveries immediately; the mux has no data storage to lose.
REQ-036 After reset release, the first accept SHALL be possible on the first rising edge.

Verification
REQ-037 Mirror accept m_c_dst_vld=4'b0101, m_c_data=8'h3C, m_p_drdy=4'b1111 -> next cycle m_p_srdy=0101, m_p_data=3C, m_c_drdy=0; following cycle m_p_srdy=0000, m_c_drdy=1.
REQ-038 Partial drain: pending 0101, m_p_drdy=0001 -> m_p_srdy becomes 0100, m_c_drdy stays 0 until bit 2 taken; data stays 3C.
REQ-039 m_c_dst_vld=0, data 8'hA5 -> m_p_srdy=1111, m_p_data=A5.
REQ-040 Mux after reset, r_c_srdy=1111, data slices 11,22,33,44, r_p_drdy=1 -> r_p_data sequence 11,22,33,44,11 on successive cycles; r_p_grant 0001,0010,0100,1000,0001.
REQ-041 Mux r_c_srdy=1010, r_p_drdy=0 -> r_p_srdy=1, r_p_grant=0010, r_c_drdy=0000, stable each cycle; raise r_p_drdy -> input 1 served, then input 3.
REQ-042 Reset asserted with m_p_srdy=0110 -> m_p_srdy=0000 and m_c_drdy=1 without waiting for a clock edge.

Source files
------------

// File: rtl/sd_mirror_rrmux.sv
// sd_mirror_rrmux: a one-to-many mirror dispatcher and an N-input fast
// round-robin mux, sharing only clock and reset.
//   Mirror: holds one item plus a pending-destination mask. Each destination
//           drains its own bit, and a new item is taken only once all bits
//           are clear.
//   Mux:    combinational arbitration with one item per grant. The
//           last-served index moves only on an output transfer.

// One pending-delivery bit of the mirror, one instance per destination.
module sd_mirror_pbit (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic load_val,
   input  logic take,
   output logic pend
);

   // Load on accept. Otherwise clear when the destination takes the item.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     pend <= 1'b0;
      else if (load)  pend <= load_val;
      else if (take)  pend <= 1'b0;
   end

endmodule

module sd_mirror_rrmux #(
   parameter int W = 8,
   parameter int M = 4,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           reset,
   // mirror side
   input  logic           m_c_srdy,
   output logic           m_c_drdy,
   input  logic [W-1:0]   m_c_data,
   input  logic [M-1:0]   m_c_dst_vld,
   output logic [M-1:0]   m_p_srdy,
   input  logic [M-1:0]   m_p_drdy,
   output logic [W-1:0]   m_p_data,
   // round-robin mux side
   input  logic [N-1:0]   r_c_srdy,
   output logic [N-1:0]   r_c_drdy,
   input  logic [N*W-1:0] r_c_data,
   output logic           r_p_srdy,
   input  logic           r_p_drdy,
   output logic [W-1:0]   r_p_data,
   output logic [N-1:0]   r_p_grant
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;

   // ---------------- mirror ----------------
   logic [M-1:0] pend;
   logic [M-1:0] load_mask;
   logic [W-1:0] dreg;
   logic         m_accept;

   // Accept only with nothing pending. In the cycle the last bit drains,
   // pend is still non-zero, which enforces the 2-cycle accept spacing.
   assign m_c_drdy  = (pend == '0);
   assign m_accept  = m_c_srdy & m_c_drdy;
   // An empty destination mask means broadcast to every destination.
   assign load_mask = (m_c_dst_vld == '0) ? '1 : m_c_dst_vld;
   assign m_p_srdy  = pend;
   assign m_p_data  = dreg;

   genvar g;
   generate
      for (g = 0; g < M; g++) begin : g_pbit
         sd_mirror_pbit u_pbit (
            .clk      (clk),
            .reset    (reset),
            .load     (m_accept),
            .load_val (load_mask[g]),
            .take     (m_p_drdy[g]),
            .pend     (pend[g])
         );
      end
   endgenerate

   // Data register changes only on accept, so it is stable while anything is pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        dreg <= '0;
      else if (m_accept) dreg <= m_c_data;
   end

   // ---------------- round-robin mux ----------------
   logic [LW-1:0] last;
   logic [LW-1:0] gidx;
   logic          gfound;
   logic [LW-1:0] probe;

   // Scan from last+1 upward, wrapping. Index 'last' is visited last, so it
   // wins only when it is the only requester.
   always_comb begin
      gidx   = '0;
      gfound = 1'b0;
      probe  = '0;
      for (int k = 1; k <= N; k++) begin
         probe = LW'((int'(last) + k) % N);
         if (!gfound && r_c_srdy[probe]) begin
            gfound = 1'b1;
            gidx   = probe;
         end
      end
   end

   // One-hot grant and the granted data slice. Both are zero with no request.
   always_comb begin
      r_p_grant = '0;
      r_p_data  = '0;
      if (gfound) begin
         r_p_grant[gidx] = 1'b1;
         r_p_data        = r_c_data[int'(gidx)*W +: W];
      end
   end

   assign r_p_srdy = |r_c_srdy;
   assign r_c_drdy = r_p_grant & {N{r_p_drdy}};

   // Priority pointer advances only on an actual output transfer.
   // After reset it points at N-1, so input 0 is served first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    last <= LW'(N-1);
      else if (r_p_srdy & r_p_drdy)  last <= gidx;
   end

endmodule

// File: tb/tb_sd_mirror_rrmux.sv
// Bench for sd_mirror_rrmux: directed checks with hand-computed literals,
// then randomized traffic compared each cycle against a behavioural model.
module tb_sd_mirror_rrmux;

   localparam int W = 8;
   localparam int M = 4;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           m_c_srdy;
   logic           m_c_drdy;
   logic [W-1:0]   m_c_data;
   logic [M-1:0]   m_c_dst_vld;
   logic [M-1:0]   m_p_srdy;
   logic [M-1:0]   m_p_drdy;
   logic [W-1:0]   m_p_data;
   logic [N-1:0]   r_c_srdy;
   logic [N-1:0]   r_c_drdy;
   logic [N*W-1:0] r_c_data;
   logic           r_p_srdy;
   logic           r_p_drdy;
   logic [W-1:0]   r_p_data;
   logic [N-1:0]   r_p_grant;

   sd_mirror_rrmux #(.W(W), .M(M), .N(N)) dut (
      .clk(clk), .reset(reset),
      .m_c_srdy(m_c_srdy), .m_c_drdy(m_c_drdy), .m_c_data(m_c_data),
      .m_c_dst_vld(m_c_dst_vld), .m_p_srdy(m_p_srdy), .m_p_drdy(m_p_drdy),
      .m_p_data(m_p_data),
      .r_c_srdy(r_c_srdy), .r_c_drdy(r_c_drdy), .r_c_data(r_c_data),
      .r_p_srdy(r_p_srdy), .r_p_drdy(r_p_drdy), .r_p_data(r_p_data),
      .r_p_grant(r_p_grant)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance one clock: pass a rising edge, then land on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   logic [M-1:0] mpend;
   logic [W-1:0] mdat;
   int           mlast;

   function automatic int mgrant(input logic [N-1:0] req, input int lst);
      for (int k = 1; k <= N; k++)
         if (req[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      mpend = '0;
      mdat  = '0;
      mlast = N - 1;
   endtask

   // Apply one rising edge to the model using the current inputs.
   task automatic model_clock();
      int g;
      if (mpend == '0) begin
         if (m_c_srdy) begin
            mdat  = m_c_data;
            mpend = (m_c_dst_vld == '0) ? {M{1'b1}} : m_c_dst_vld;
         end
      end else begin
         mpend = mpend & ~m_p_drdy;
      end
      g = mgrant(r_c_srdy, mlast);
      if (g >= 0 && r_p_drdy) mlast = g;
   endtask

   task automatic check_all();
      int           g;
      logic [N-1:0] eg;
      logic [W-1:0] ed;
      g  = mgrant(r_c_srdy, mlast);
      eg = '0;
      ed = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         ed    = r_c_data[g*W +: W];
      end
      chk("m_c_drdy",  m_c_drdy,  (mpend == '0));
      chk("m_p_srdy",  m_p_srdy,  mpend);
      chk("m_p_data",  m_p_data,  mdat);
      chk("r_p_srdy",  r_p_srdy,  |r_c_srdy);
      chk("r_p_grant", r_p_grant, eg);
      chk("r_p_data",  r_p_data,  ed);
      chk("r_c_drdy",  r_c_drdy,  eg & {N{r_p_drdy}});
   endtask

   initial begin
      logic [W-1:0] exp_d [5];
      logic [N-1:0] exp_g [5];
      logic         in_rst;
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      reset = 1'b0;
      m_c_srdy = 1'b0; m_c_data = '0; m_c_dst_vld = '0; m_p_drdy = '0;
      r_c_srdy = '0; r_c_data = '0; r_p_drdy = 1'b0;
      #2;
      chk("rst_m_p_srdy",  m_p_srdy,  4'b0000);
      chk("rst_m_c_drdy",  m_c_drdy,  1'b1);
      chk("rst_m_p_data",  m_p_data,  8'h00);
      chk("rst_r_p_srdy",  r_p_srdy,  1'b0);
      chk("rst_r_p_grant", r_p_grant, 4'b0000);
      chk("rst_r_p_data",  r_p_data,  8'h00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Full-drain mirror item
      m_c_srdy = 1'b1; m_c_dst_vld = 4'b0101; m_c_data = 8'h3C; m_p_drdy = 4'b1111;
      #1 chk("d1_drdy_idle", m_c_drdy, 1'b1);
      step();
      m_c_srdy = 1'b0;
      #1;
      chk("d1_srdy", m_p_srdy, 4'b0101);
      chk("d1_data", m_p_data, 8'h3C);
      chk("d1_drdy", m_c_drdy, 1'b0);
      step();
      #1;
      chk("d1_srdy_done", m_p_srdy, 4'b0000);
      chk("d1_drdy_done", m_c_drdy, 1'b1);

      // Partial drain
      m_c_srdy = 1'b1; m_c_dst_vld = 4'b0101; m_c_data = 8'h3C; m_p_drdy = 4'b0001;
      step();
      m_c_srdy = 1'b0;
      #1 chk("d2_srdy0", m_p_srdy, 4'b0101);
      step();
      #1;
      chk("d2_srdy1", m_p_srdy, 4'b0100);
      chk("d2_drdy1", m_c_drdy, 1'b0);
      chk("d2_data1", m_p_data, 8'h3C);
      step();
      #1 chk("d2_srdy2", m_p_srdy, 4'b0100);
      m_p_drdy = 4'b0100;
      step();
      #1 chk("d2_drdy_done", m_c_drdy, 1'b1);

      // Empty destination mask broadcasts
      m_c_srdy = 1'b1; m_c_dst_vld = 4'b0000; m_c_data = 8'hA5; m_p_drdy = 4'b0000;
      step();
      m_c_srdy = 1'b0;
      #1;
      chk("d3_srdy", m_p_srdy, 4'b1111);
      chk("d3_data", m_p_data, 8'hA5);

      // Asynchronous reset discards pending deliveries
      m_p_drdy = 4'b1001;
      step();
      m_p_drdy = 4'b0000;
      #1 chk("d4_srdy_pre", m_p_srdy, 4'b0110);
      #1 reset = 1'b0;
      #1;
      chk("d4_srdy_rst", m_p_srdy, 4'b0000);
      chk("d4_drdy_rst", m_c_drdy, 1'b1);
      step();
      reset = 1'b1;
      m_c_srdy = 1'b1; m_c_dst_vld = 4'b1000; m_c_data = 8'h5A;
      step();
      m_c_srdy = 1'b0;
      #1;
      chk("d4_first_acc", m_p_srdy, 4'b1000);
      chk("d4_first_dat", m_p_data, 8'h5A);
      m_p_drdy = 4'b1111;
      step();
      m_p_drdy = 4'b0000;

      // Mux rotation from reset priority
      r_c_data = {8'h44, 8'h33, 8'h22, 8'h11};
      r_c_srdy = 4'b1111; r_p_drdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         #1;
         chk("d5_data",  r_p_data,  exp_d[i]);
         chk("d5_grant", r_p_grant, exp_g[i]);
      end

      // Hold with no output ready, then serve
      r_c_srdy = 4'b1010; r_p_drdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         #1;
         chk("d6_srdy",  r_p_srdy,  1'b1);
         chk("d6_grant", r_p_grant, 4'b0010);
         chk("d6_cdrdy", r_c_drdy,  4'b0000);
      end
      r_p_drdy = 1'b1;
      #1;
      chk("d6_serve1", r_c_drdy, 4'b0010);
      chk("d6_data1",  r_p_data, 8'h22);
      step();
      #1;
      chk("d6_serve3", r_p_grant, 4'b1000);
      chk("d6_data3",  r_p_data,  8'h44);
      r_c_srdy = 4'b0000;
      #1;
      chk("d6_idle_srdy",  r_p_srdy,  1'b0);
      chk("d6_idle_data",  r_p_data,  8'h00);
      chk("d6_idle_grant", r_p_grant, 4'b0000);

      // Randomized traffic against the model
      reset = 1'b0;
      model_reset();
      in_rst = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (in_rst) begin
            reset  = 1'b1;
            in_rst = 1'b0;
         end
         m_c_srdy    = ($urandom % 3) != 0;
         m_c_dst_vld = M'($urandom);
         m_c_data    = W'($urandom);
         m_p_drdy    = M'($urandom) & M'($urandom);
         r_c_srdy    = N'($urandom);
         r_c_data    = {$urandom, $urandom};
         r_p_drdy    = ($urandom % 4) != 0;
         #1 check_all();
         if ($urandom % 150 == 0) begin
            #1 reset = 1'b0;
            #1;
            chk("rnd_rst_srdy", m_p_srdy, 4'b0000);
            chk("rnd_rst_drdy", m_c_drdy, 1'b1);
            model_reset();
            in_rst = 1'b1;
            @(posedge clk);
         end else begin
            @(posedge clk);
            model_clock();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
